ts_slot_scheduler: RTL and testbench
====================================

Name: ts_slot_scheduler

Overview:
- Per-packet-slot scheduler for the TS output stream of the T2-MI gateway.
- At each 188-byte output slot it selects the source for that slot: PSI generator (PAT/PMT), T2-MI-over-TS packetizer, or null-packet generator.
- It fires that source's START pulse, drives the output mux select, and counts the source's byte strobes to close the slot.
- It also owns the PSI repetition timer, overrun/timeout flags and per-source packet counters.

Parameters:
- PKT_LEN, 188, bytes per TS packet; slot closes after this many selected-source strobes.
- PSI_PERIOD, 1000, completed slots between PSI insertions (PAT+PMT pair); legal range 2..65535.
- TIMEOUT, 1023, max CLK cycles spent in COUNT before the slot is aborted.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- SLOT_TICK  in  1  one-cycle pulse from the output rate generator marking the start of an output slot.
- T2MI_AVAIL  in  1  packetizer input FIFO holds at least one packet's payload.
- ENA_T2MI  in  1  packetizer byte strobe.
- ENA_PSI  in  1  PSI generator byte strobe.
- ENA_NULL  in  1  null generator byte strobe.
- START_T2MI  out  1  one-cycle start pulse to the packetizer.
- START_PSI  out  1  one-cycle start pulse to the PSI generator.
- START_NULL  out  1  one-cycle start pulse to the null generator.
- PSI_TABLE  out  1  table for the current PSI slot: 0 = PAT, 1 = PMT.
- SEL  out  2  output mux select: 0 = null, 1 = T2MI, 2 = PSI; 3 is never driven.
- BUSY  out  1  high while the FSM is outside IDLE.
- OVERRUN  out  1  one-cycle pulse when SLOT_TICK arrives outside IDLE.
- TIMEOUT_ERR  out  1  one-cycle pulse when a slot is aborted by timeout.
- T2MI_CNT  out  16  completed T2MI slots, wraps modulo 2^16.
- NULL_CNT  out  16  completed null slots, wraps modulo 2^16.
- state_mon  out  3  current FSM state code.

Behaviour:
- Reset (RST high, asynchronous):
  - FSM to IDLE; all pulses, BUSY and SEL go to 0.
  - PSI_TABLE, byte counter, timeout counter, PSI timer, psi_due, T2MI_CNT and NULL_CNT go to 0.
  - Reset mid-slot aborts the slot without incrementing any counter.
- State codes: IDLE = 0, ARB = 1, START = 2, COUNT = 3, DONE = 4.
- IDLE: on SLOT_TICK go to ARB next cycle.
- ARB (1 cycle), priority order:
  - psi_due: SEL = 2.
  - else T2MI_AVAIL: SEL = 1.
  - else: SEL = 0.
  - SEL is registered and held constant from the ARB exit through DONE.
- START (1 cycle):
  - Assert only the START_x matching SEL.
  - Clear the byte and timeout counters; go to COUNT.
  - Latency is fixed: START_x is high exactly 2 cycles after the SLOT_TICK cycle.
- COUNT:
  - Byte counter increments on the selected source's ENA only; strobes from unselected sources are ignored.
  - When the count reaches PKT_LEN (the cycle of the 188th strobe), go to DONE.
  - Timeout counter increments every cycle. If it reaches TIMEOUT before the count completes: pulse TIMEOUT_ERR and go to DONE with the abort flag set.
  - If the 188th strobe and the timeout occur in the same cycle, the completion wins and no error is flagged.
- DONE (1 cycle), then IDLE:
  - Aborted slot: counters, PSI timer and PSI_TABLE are all left unchanged, so an aborted PSI slot is retried.
  - Completed SEL = 1: T2MI_CNT + 1.
  - Completed SEL = 0: NULL_CNT + 1.
  - Completed SEL = 2 with PSI_TABLE = 0: PSI_TABLE set to 1, psi_due stays set, so the PMT follows in the next slot.
  - Completed SEL = 2 with PSI_TABLE = 1: PSI_TABLE set to 0, psi_due cleared.
  - PSI timer, on any completed slot: increments while psi_due = 0. On reaching PSI_PERIOD−1 it wraps to 0 and sets psi_due. It holds while psi_due = 1.
- SLOT_TICK in any state other than IDLE: one-cycle OVERRUN pulse; the tick is dropped with no queuing. A tick in the same cycle DONE exits is also dropped.
- BUSY = 1 in ARB, START, COUNT and DONE.
- ENA strobes seen in IDLE, ARB or DONE are ignored.

Test Plan:
- T2MI_AVAIL = 1, one SLOT_TICK, packetizer model returns 188 ENA_T2MI strobes → START_T2MI 2 cycles after the tick, SEL = 1 throughout, T2MI_CNT = 1, back in IDLE, BUSY = 0.
- T2MI_AVAIL = 0, 3 ticks with null model responding → 3 START_NULL pulses, SEL = 0, NULL_CNT = 3.
- PSI_PERIOD = 4, T2MI always available, 10 well-spaced ticks → source order T,T,T,PAT,PMT,T,T,T,PAT,PMT, with PSI_TABLE 0 then 1 on each PSI pair.
- Selected source stops after 100 strobes → TIMEOUT_ERR pulse TIMEOUT cycles after START, no counter increments, next tick reselects the same source.
- Second SLOT_TICK while in COUNT → one OVERRUN pulse; current slot completes normally with exactly 188 counted strobes.
- RST asserted in COUNT after 50 strobes → immediate IDLE, all outputs 0, counters 0; next tick runs a normal slot. ENA_NULL strobes injected during a T2MI slot → ignored, slot still needs 188 ENA_T2MI.

Source files
------------

// File: rtl/ts_slot_scheduler_if.sv
// rtl/ts_slot_scheduler_if.sv - slot scheduler source handshake and status bundle
interface ts_slot_scheduler_if;
  logic        SLOT_TICK;
  logic        T2MI_AVAIL;
  logic        ENA_T2MI;
  logic        ENA_PSI;
  logic        ENA_NULL;
  logic        START_T2MI;
  logic        START_PSI;
  logic        START_NULL;
  logic        PSI_TABLE;
  logic [1:0]  SEL;
  logic        BUSY;
  logic        OVERRUN;
  logic        TIMEOUT_ERR;
  logic [15:0] T2MI_CNT;
  logic [15:0] NULL_CNT;
  logic [2:0]  state_mon;

  // rate generator and the three sources drive ticks and strobes
  modport master (
    output SLOT_TICK, T2MI_AVAIL, ENA_T2MI, ENA_PSI, ENA_NULL,
    input  START_T2MI, START_PSI, START_NULL, PSI_TABLE, SEL, BUSY,
           OVERRUN, TIMEOUT_ERR, T2MI_CNT, NULL_CNT, state_mon
  );

  // scheduler side
  modport slave (
    input  SLOT_TICK, T2MI_AVAIL, ENA_T2MI, ENA_PSI, ENA_NULL,
    output START_T2MI, START_PSI, START_NULL, PSI_TABLE, SEL, BUSY,
           OVERRUN, TIMEOUT_ERR, T2MI_CNT, NULL_CNT, state_mon
  );
endinterface

// File: rtl/ts_slot_scheduler.sv
// rtl/ts_slot_scheduler.sv - per-slot TS source arbiter with PSI repetition timer
module ts_slot_scheduler #(
  parameter int PKT_LEN    = 188,
  parameter int PSI_PERIOD = 1000,
  parameter int TIMEOUT    = 1023
) (
  input logic               CLK,
  input logic               RST,
  ts_slot_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    COUNT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int BW = $clog2(PKT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(PKT_LEN - 1);
  // abort decided so that TIMEOUT_ERR lands exactly TIMEOUT cycles after START_x
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 2);
  // timer value whose increment would reach PSI_PERIOD-1
  localparam logic [15:0]   PSI_WRAP  = 16'(PSI_PERIOD - 2);

  state_t        state;
  logic [1:0]    sel;
  logic          start_t2mi, start_psi, start_null;
  logic          psi_table;
  logic          busy;
  logic          overrun;
  logic          timeout_err;
  logic          aborted;
  logic          psi_due;
  logic [15:0]   psi_timer;
  logic [15:0]   t2mi_cnt, null_cnt;
  logic [BW-1:0] byte_cnt;
  logic [TW-1:0] to_cnt;
  logic          ena_sel;

  // strobe of the currently selected source; others never reach the counter
  always_comb begin
    case (sel)
      2'd1:    ena_sel = bus.ENA_T2MI;
      2'd2:    ena_sel = bus.ENA_PSI;
      default: ena_sel = bus.ENA_NULL;
    endcase
  end

  // slot FSM with registered pulses, mux select, PSI timer and slot counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      sel         <= 2'd0;
      start_t2mi  <= 1'b0;
      start_psi   <= 1'b0;
      start_null  <= 1'b0;
      psi_table   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      aborted     <= 1'b0;
      psi_due     <= 1'b0;
      psi_timer   <= 16'd0;
      t2mi_cnt    <= 16'd0;
      null_cnt    <= 16'd0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      start_t2mi  <= 1'b0;
      start_psi   <= 1'b0;
      start_null  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      // ticks outside IDLE are dropped, never queued
      if (bus.SLOT_TICK && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.SLOT_TICK) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          state <= START;
          if (psi_due) begin
            sel       <= 2'd2;
            start_psi <= 1'b1;
          end else if (bus.T2MI_AVAIL) begin
            sel        <= 2'd1;
            start_t2mi <= 1'b1;
          end else begin
            sel        <= 2'd0;
            start_null <= 1'b1;
          end
        end
        START: begin
          byte_cnt <= '0;
          to_cnt   <= '0;
          aborted  <= 1'b0;
          state    <= COUNT;
        end
        COUNT: begin
          to_cnt <= to_cnt + 1'b1;
          if (ena_sel) byte_cnt <= byte_cnt + 1'b1;
          // completion takes priority over a simultaneous timeout
          if (ena_sel && byte_cnt == BYTE_LAST) begin
            state <= DONE;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            aborted     <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!aborted) begin
            case (sel)
              2'd1: t2mi_cnt <= t2mi_cnt + 16'd1;
              2'd2: begin
                psi_table <= ~psi_table;
                if (psi_table) psi_due <= 1'b0;
              end
              default: null_cnt <= null_cnt + 16'd1;
            endcase
            if (!psi_due) begin
              if (psi_timer == PSI_WRAP) begin
                psi_timer <= 16'd0;
                psi_due   <= 1'b1;
              end else begin
                psi_timer <= psi_timer + 16'd1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.START_T2MI  = start_t2mi;
  assign bus.START_PSI   = start_psi;
  assign bus.START_NULL  = start_null;
  assign bus.PSI_TABLE   = psi_table;
  assign bus.SEL         = sel;
  assign bus.BUSY        = busy;
  assign bus.OVERRUN     = overrun;
  assign bus.TIMEOUT_ERR = timeout_err;
  assign bus.T2MI_CNT    = t2mi_cnt;
  assign bus.NULL_CNT    = null_cnt;
  assign bus.state_mon   = state;

endmodule

// File: tb/tb_ts_slot_scheduler.sv
// tb/tb_ts_slot_scheduler.sv - scoreboard bench for the TS slot scheduler
module tb_ts_slot_scheduler;
  localparam int PKT_LEN    = 188;
  localparam int PSI_PERIOD = 4;
  localparam int TIMEOUT    = 400;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  ts_slot_scheduler_if bus ();

  ts_slot_scheduler #(
    .PKT_LEN   (PKT_LEN),
    .PSI_PERIOD(PSI_PERIOD),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] src;
    logic       tbl;
  } slot_t;

  slot_t exp_q[$];
  int    exp_to_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    last_tick = -100;
  int    last_start = -100;
  int    overrun_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a start or timeout pulse
  always @(negedge CLK) begin
    slot_t e;
    int    got;
    cyc++;
    if (bus.SLOT_TICK) last_tick = cyc;
    if (bus.OVERRUN) overrun_seen++;
    if (bus.START_T2MI || bus.START_PSI || bus.START_NULL) begin
      last_start = cyc;
      check("start_onehot", int'(bus.START_T2MI) + int'(bus.START_PSI) + int'(bus.START_NULL), 1);
      got = bus.START_PSI ? 2 : (bus.START_T2MI ? 1 : 0);
      if (exp_q.size() == 0) begin
        check("start_unexpected", got, -1);
      end else begin
        e = exp_q.pop_front();
        check("start_src", got, int'(e.src));
        check("start_sel", int'(bus.SEL), int'(e.src));
        check("start_latency", cyc - last_tick, 2);
        if (e.src == 2'd2) check("psi_table", int'(bus.PSI_TABLE), int'(e.tbl));
      end
    end
    if (bus.TIMEOUT_ERR) begin
      if (exp_to_q.size() == 0) check("timeout_unexpected", 1, 0);
      else check("timeout_latency", cyc - last_start, exp_to_q.pop_front());
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ena(input int src, input logic v);
    case (src)
      0:       bus.ENA_NULL = v;
      1:       bus.ENA_T2MI = v;
      default: bus.ENA_PSI  = v;
    endcase
  endtask

  task automatic check_zero();
    check("rst_state", int'(bus.state_mon), 0);
    check("rst_busy", int'(bus.BUSY), 0);
    check("rst_sel", int'(bus.SEL), 0);
    check("rst_table", int'(bus.PSI_TABLE), 0);
    check("rst_t2mi_cnt", int'(bus.T2MI_CNT), 0);
    check("rst_null_cnt", int'(bus.NULL_CNT), 0);
    check("rst_pulses", int'({bus.START_T2MI, bus.START_PSI, bus.START_NULL, bus.OVERRUN, bus.TIMEOUT_ERR}), 0);
  endtask

  // one slot: tick, wait for start, drive n strobes of the expected source
  task automatic run_slot(input int src, input logic tbl, input int n, input bit noise,
                          input bit extra_tick, input bit expect_to, input bit do_rst);
    slot_t s;
    int    sel_bad;
    bit    seen;
    bit    done;
    sel_bad = 0;
    seen = 0;
    done = 0;
    s.src = 2'(src);
    s.tbl = tbl;
    exp_q.push_back(s);
    if (expect_to) exp_to_q.push_back(TIMEOUT);
    bus.SLOT_TICK = 1'b1;
    step();
    bus.SLOT_TICK = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      seen = bus.START_T2MI | bus.START_PSI | bus.START_NULL;
    end
    check("start_seen", int'(seen), 1);
    for (int i = 0; i < n; i++) begin
      step();
      if (i == n - 1 && n == PKT_LEN) check("count_before_last", int'(bus.state_mon), 3);
      bus.SLOT_TICK = (extra_tick && i == 20);
      set_ena(src, 1'b1);
      if (int'(bus.SEL) != src) sel_bad++;
      if (noise) begin
        step();
        set_ena(src, 1'b0);
        bus.ENA_NULL = 1'b1;
      end
    end
    step();
    set_ena(src, 1'b0);
    bus.ENA_NULL  = 1'b0;
    bus.SLOT_TICK = 1'b0;
    check("sel_held", sel_bad, 0);
    if (do_rst) begin
      RST = 1'b1;
      #1;
      check_zero();
      step();
      RST = 1'b0;
      step();
    end else begin
      for (int i = 0; i < TIMEOUT + 20 && !done; i++) begin
        done = (bus.state_mon == 3'd0);
        if (!done) step();
      end
      check("slot_end_idle", int'(done), 1);
      check("busy_after", int'(bus.BUSY), 0);
      step();
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov0;
    bus.SLOT_TICK  = 1'b0;
    bus.T2MI_AVAIL = 1'b0;
    bus.ENA_T2MI   = 1'b0;
    bus.ENA_PSI    = 1'b0;
    bus.ENA_NULL   = 1'b0;
    RST = 1'b1;
    repeat (3) step();
    check_zero();
    RST = 1'b0;
    step();

    // three null slots; the third completion makes PSI due
    repeat (3) run_slot(0, 1'b0, PKT_LEN, 0, 0, 0, 0);
    check("null_cnt_3", int'(bus.NULL_CNT), 3);
    check("t2mi_cnt_0", int'(bus.T2MI_CNT), 0);

    // PAT slot interrupted by reset after 50 strobes
    bus.T2MI_AVAIL = 1'b1;
    run_slot(2, 1'b0, 50, 0, 0, 0, 1);

    // clean T2MI slot after reset: PSI no longer due
    run_slot(1, 1'b0, PKT_LEN, 0, 0, 0, 0);
    check("t2mi_cnt_1", int'(bus.T2MI_CNT), 1);
    check("idle_after_t2mi", int'(bus.state_mon), 0);

    // null strobes during a T2MI slot must not count
    run_slot(1, 1'b0, PKT_LEN, 1, 0, 0, 0);
    check("t2mi_cnt_noise", int'(bus.T2MI_CNT), 2);
    check("null_cnt_noise", int'(bus.NULL_CNT), 0);

    // source stalls after 100 strobes: abort, no count, same source retried
    run_slot(1, 1'b0, 100, 0, 0, 1, 0);
    check("t2mi_cnt_abort", int'(bus.T2MI_CNT), 2);
    check("timeout_consumed", exp_to_q.size(), 0);
    run_slot(1, 1'b0, PKT_LEN, 0, 0, 0, 0);
    check("t2mi_cnt_retry", int'(bus.T2MI_CNT), 3);

    // fresh PSI timer; order T,T,T,PAT,PMT repeated, first slot sees an overrun tick
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    ov0 = overrun_seen;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 >= 3) run_slot(2, logic'(k % 5 == 4), PKT_LEN, 0, 0, 0, 0);
      else run_slot(1, 1'b0, PKT_LEN, 0, (k == 0), 0, 0);
    end
    check("overrun_pulses", overrun_seen - ov0, 1);
    check("t2mi_cnt_order", int'(bus.T2MI_CNT), 6);
    check("table_after_pmt", int'(bus.PSI_TABLE), 0);
    check("exp_q_empty", exp_q.size(), 0);
    check("exp_to_empty", exp_to_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
